// File: rtl/popc_pkg.sv
// Shared types and derived-width helpers for the popcount accumulator slice.
package popc_pkg;

  typedef enum logic [1:0] {PC_IDLE, PC_ACCUM, PC_DRAIN, PC_DONE} popc_state_e;

  function automatic int popc_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int acc_w(input int n, input int max_beats);
    return $clog2(n * max_beats) + 1;
  endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count of an N-bit word; zero latency, no flow control.
module popcount
  import popc_pkg::*;
#(
  parameter int  N = 512,
  localparam int W = popc_w(N)
) (
  input  logic [N-1:0] data_i,
  output logic [W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + W'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_accum_ctrl.sv
// Streams a job's beats through one popcount and returns the summed total via valid/ready.
// Result valid two cycles after the last beat handshake; ready outputs depend on state only.
module popcount_accum_ctrl
  import popc_pkg::*;
#(
  parameter int  N         = 512,
  parameter int  MAX_BEATS = 16,
  localparam int POPC_W    = popc_w(N),
  localparam int ACC_W     = acc_w(N, MAX_BEATS),
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_valid_i,
  output logic              start_ready_o,
  input  logic [BEAT_W-1:0] num_beats_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [N-1:0]      data_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [ACC_W-1:0]  result_o,
  output logic              busy_o
);

  localparam logic [BEAT_W-1:0] MAX_B = BEAT_W'(MAX_BEATS);

  popc_state_e       state_q, state_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [POPC_W-1:0] popc_q, popc_d;
  logic              pipe_vld_q, pipe_vld_d;
  logic [ACC_W-1:0]  acc_q, acc_d;

  logic [POPC_W-1:0] popc_cnt;
  logic [BEAT_W-1:0] beats_clamped;
  logic              start_hs, data_hs, last_beat;

  popcount #(.N(N)) u_popcount (
    .data_i  (data_i),
    .count_o (popc_cnt)
  );

  assign start_ready_o  = (state_q == PC_IDLE);
  assign data_ready_o   = (state_q == PC_ACCUM);
  assign result_valid_o = (state_q == PC_DONE);
  assign busy_o         = (state_q != PC_IDLE);
  assign result_o       = acc_q;

  assign start_hs      = start_valid_i & start_ready_o;
  assign data_hs       = data_valid_i & data_ready_o;
  assign beats_clamped = (num_beats_i > MAX_B) ? MAX_B : num_beats_i;
  assign last_beat     = (beat_cnt_q == beats_q - BEAT_W'(1));

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    popc_d     = popc_q;
    pipe_vld_d = data_hs;
    acc_d      = acc_q;

    if (pipe_vld_q) acc_d = acc_q + ACC_W'(popc_q);
    if (data_hs) begin
      popc_d     = popc_cnt;
      beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end

    case (state_q)
      PC_IDLE: begin
        if (start_hs) begin
          beats_d    = beats_clamped;
          beat_cnt_d = '0;
          acc_d      = '0;
          state_d    = (beats_clamped == '0) ? PC_DONE : PC_ACCUM;
        end
      end
      PC_ACCUM: if (data_hs && last_beat) state_d = PC_DRAIN;
      // The final partial count is folded in by the pipe_vld add above.
      PC_DRAIN: state_d = PC_DONE;
      PC_DONE:  if (result_ready_i) state_d = PC_IDLE;
      default:  state_d = PC_IDLE;
    endcase

    if (clear_i) begin
      state_d    = PC_IDLE;
      acc_d      = '0;
      beat_cnt_d = '0;
      pipe_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= PC_IDLE;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      popc_q     <= '0;
      pipe_vld_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      popc_q     <= popc_d;
      pipe_vld_q <= pipe_vld_d;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: tb/tb_popcount_accum_ctrl.sv
// Randomized self-checking bench for popcount_accum_ctrl against a job-level reference model.
module tb_popcount_accum_ctrl;

  localparam int N      = 512;
  localparam int MB     = 16;
  localparam int ACC_W  = $clog2(N * MB) + 1;
  localparam int BEAT_W = $clog2(MB + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              start_valid;
  logic              start_ready;
  logic [BEAT_W-1:0] num_beats;
  logic              data_valid;
  logic              data_ready;
  logic [N-1:0]      data;
  logic              result_valid;
  logic              result_ready;
  logic [ACC_W-1:0]  result;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] beat_mem [MB];

  always #5 clk = ~clk;

  popcount_accum_ctrl #(.N(N), .MAX_BEATS(MB)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clear),
    .start_valid_i  (start_valid),
    .start_ready_o  (start_ready),
    .num_beats_i    (num_beats),
    .data_valid_i   (data_valid),
    .data_ready_o   (data_ready),
    .data_i         (data),
    .result_valid_o (result_valid),
    .result_ready_i (result_ready),
    .result_o       (result),
    .busy_o         (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    for (int i = 0; i < N / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_start_rdy"}, start_ready, 1);
    check_eq({tag, "_data_rdy"}, data_ready, 0);
    check_eq({tag, "_res_vld"}, result_valid, 0);
    check_eq({tag, "_result"}, result, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // Runs one job from beat_mem; expected total is the set-bit count of the clamped beat set.
  task automatic run_job(input int n, input int gap_pct, input int hold, output int got);
    int eff;
    int exp_sum;
    logic [ACC_W-1:0] held;
    eff     = (n > MB) ? MB : n;
    exp_sum = 0;
    for (int i = 0; i < eff; i++) exp_sum += $countones(beat_mem[i]);

    check_eq("idle_start_rdy", start_ready, 1);
    check_eq("idle_busy", busy, 0);
    start_valid = 1'b1;
    num_beats   = BEAT_W'(n);
    @(negedge clk);
    start_valid = 1'b0;
    check_eq("job_busy", busy, 1);

    for (int b = 0; b < eff; b++) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        data_valid = 1'b0;
        data       = rand_word();
        @(negedge clk);
        check_eq("gap_data_rdy", data_ready, 1);
      end
      data_valid = 1'b1;
      data       = beat_mem[b];
      check_eq("beat_data_rdy", data_ready, 1);
      @(negedge clk);
    end

    // Keep offering beats past the job end; they must be ignored.
    data_valid = 1'b1;
    data       = {N{1'b1}};
    if (eff > 0) begin
      check_eq("drain_res_vld", result_valid, 0);
      check_eq("drain_data_rdy", data_ready, 0);
      @(negedge clk);
    end
    check_eq("done_res_vld", result_valid, 1);
    check_eq("done_data_rdy", data_ready, 0);
    check_eq("done_result", result, exp_sum);
    got  = int'(result);
    held = result;

    start_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_res_vld", result_valid, 1);
      check_eq("hold_result", result, held);
      check_eq("hold_start_rdy", start_ready, 0);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    data_valid   = 1'b0;
    check_eq("ack_res_vld", result_valid, 0);
    check_eq("ack_start_rdy", start_ready, 1);
  endtask

  initial begin
    int got;
    int n;
    rst = 1'b1; clear = 1'b0; start_valid = 1'b0; num_beats = '0;
    data_valid = 1'b0; data = '0; result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;
    @(negedge clk);

    // Mid-stream asynchronous reset.
    start_valid = 1'b1; num_beats = BEAT_W'(5);
    @(negedge clk);
    start_valid = 1'b0;
    data_valid  = 1'b1; data = {N{1'b1}};
    repeat (2) @(negedge clk);
    check_eq("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back all-ones.
    for (int i = 0; i < 3; i++) beat_mem[i] = {N{1'b1}};
    run_job(3, 0, 0, got);
    check_eq("t2_const", got, 1536);

    // Small patterns with gaps and a stalled consumer.
    for (int i = 0; i < 4; i++) begin
      beat_mem[i] = '0;
      beat_mem[i][3:0] = 4'((1 << (i + 1)) - 1);
    end
    run_job(4, 40, 5, got);
    check_eq("t3_const", got, 10);

    run_job(0, 0, 1, got);
    check_eq("t4_const", got, 0);

    for (int i = 0; i < MB; i++) beat_mem[i] = {N{1'b1}};
    run_job(31, 0, 0, got);
    check_eq("t5_const", got, 8192);

    // Clear on the second of three beats, then a fresh job.
    start_valid = 1'b1; num_beats = BEAT_W'(3);
    @(negedge clk);
    start_valid = 1'b0;
    data_valid  = 1'b1; data = {N{1'b1}};
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; data_valid = 1'b0;
    check_eq("clr_busy", busy, 0);
    check_eq("clr_start_rdy", start_ready, 1);
    check_eq("clr_res_vld", result_valid, 0);
    beat_mem[0] = '0;
    beat_mem[0][7:0] = 8'hFF;
    run_job(1, 0, 0, got);
    check_eq("t6_const", got, 8);

    // Clear while a result is pending wins over the result handshake.
    start_valid = 1'b1; num_beats = BEAT_W'(0);
    @(negedge clk);
    start_valid = 1'b0;
    check_eq("clr_done_pre", result_valid, 1);
    clear = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; result_ready = 1'b0;
    check_eq("clr_done_vld", result_valid, 0);
    check_eq("clr_done_result", result, 0);

    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(20);
      for (int i = 0; i < MB; i++) beat_mem[i] = rand_word();
      run_job(n, $urandom_range(60), $urandom_range(3), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
